// File: rtl/lfsr4_prbs_checker.sv
// Self-synchronising receive checker for the x^4+x^3+1 PRBS stream.
// Hunts for lock, then flywheels on its own prediction and counts bit errors.
module lfsr4_prbs_checker #(
  parameter int unsigned LOCK_CNT = 8,
  parameter int unsigned LOSS_CNT = 4,
  parameter int unsigned ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             err_clr,
  output logic             locked,
  output logic             error_pulse,
  output logic [ERR_W-1:0] error_count
);

  // state   | meaning
  // FILL    | loading the first 4 history bits, no comparisons
  // HUNT    | comparing and shifting received bits until LOCK_CNT matches in a row
  // LOCKED  | flywheel on prediction; mismatches pulse and count
  typedef enum logic [1:0] {
    ST_FILL,
    ST_HUNT,
    ST_LOCKED
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       hist_q, hist_d;
  logic [1:0]       fill_q, fill_d;
  logic [3:0]       match_q, match_d;
  logic [3:0]       bad_q, bad_d;
  logic             locked_q, locked_d;
  logic             pulse_q, pulse_d;
  logic [ERR_W-1:0] cnt_q, cnt_d;

  logic       pred;
  logic [3:0] hist_new;
  logic [3:0] match_nxt;
  logic [3:0] bad_nxt;

  assign pred = hist_q[3] ^ hist_q[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_FILL;
      hist_q   <= '0;
      fill_q   <= '0;
      match_q  <= '0;
      bad_q    <= '0;
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
      bad_q    <= bad_d;
      locked_q <= locked_d;
      pulse_q  <= pulse_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    match_d   = match_q;
    bad_d     = bad_q;
    locked_d  = locked_q;
    pulse_d   = 1'b0;
    cnt_d     = cnt_q;
    hist_new  = {hist_q[2:0], bit_in};
    match_nxt = '0;
    bad_nxt   = bad_q + 4'd1;

    if (bit_valid) begin
      case (state_q)
        ST_FILL: begin
          hist_d = hist_new;
          if (fill_q == 2'd3) begin
            state_d = ST_HUNT;
            fill_d  = '0;
            match_d = '0;
          end else begin
            fill_d = fill_q + 2'd1;
          end
        end
        ST_HUNT: begin
          hist_d    = hist_new;
          match_nxt = (bit_in == pred) ? match_q + 4'd1 : 4'd0;
          // An all-zero history is the LFSR lock-up state; never accept it.
          if (hist_new == 4'd0) match_nxt = '0;
          if (match_nxt == 4'(LOCK_CNT)) begin
            state_d  = ST_LOCKED;
            locked_d = 1'b1;
            bad_d    = '0;
            match_d  = '0;
          end else begin
            match_d = match_nxt;
          end
        end
        ST_LOCKED: begin
          // Shift in the prediction so a received error never poisons history.
          hist_d = {hist_q[2:0], pred};
          if (bit_in != pred) begin
            pulse_d = 1'b1;
            if (cnt_q != {ERR_W{1'b1}}) cnt_d = cnt_q + ERR_W'(1);
            if (bad_nxt == 4'(LOSS_CNT)) begin
              state_d  = ST_FILL;
              locked_d = 1'b0;
              fill_d   = '0;
              match_d  = '0;
              bad_d    = '0;
            end else begin
              bad_d = bad_nxt;
            end
          end else begin
            bad_d = '0;
          end
        end
        default: state_d = ST_FILL;
      endcase
    end

    if (err_clr) cnt_d = '0;
  end

  assign locked      = locked_q;
  assign error_pulse = pulse_q;
  assign error_count = cnt_q;

endmodule

// File: tb/tb_lfsr4_prbs_checker.sv
// Directed bench for lfsr4_prbs_checker: lock timing, error counting, loss/relock,
// saturation (ERR_W=4 instance), err_clr priority, bit_valid gaps and async reset.
module tb_lfsr4_prbs_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        err_clr = 1'b0;
  logic        locked_a, pulse_a, locked_b, pulse_b;
  logic [15:0] count_a;
  logic [3:0]  count_b;

  int n_cmp = 0;
  int n_bad = 0;
  logic [0:14] pat;
  int pos;

  always #5 clk = ~clk;

  lfsr4_prbs_checker dut_a (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .err_clr(err_clr),
    .locked(locked_a), .error_pulse(pulse_a), .error_count(count_a)
  );

  lfsr4_prbs_checker #(.ERR_W(4)) dut_b (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .err_clr(err_clr),
    .locked(locked_b), .error_pulse(pulse_b), .error_count(count_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic b, input logic v);
    @(negedge clk);
    bit_in    = b;
    bit_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic send_stream(input logic flip);
    send(pat[pos] ^ flip, 1'b1);
    pos = (pos + 1) % 15;
  endtask

  task automatic do_reset();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    err_clr   = 1'b0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int first_lock;
    int pulses;
    int nv;
    int ever;
    logic v;

    pat = 15'b000100110101111;

    do_reset();
    chk("reset_locked", 32'(locked_a), 0);
    chk("reset_pulse", 32'(pulse_a), 0);
    chk("reset_count", 32'(count_a), 0);

    // Clean stream: lock on valid bit 12, no errors over 100 bits.
    pos = 0; first_lock = 0; pulses = 0;
    for (int k = 1; k <= 100; k++) begin
      send_stream(1'b0);
      if (locked_a && first_lock == 0) first_lock = k;
      if (pulse_a) pulses++;
    end
    chk("clean_lock_bit", 32'(first_lock), 12);
    chk("clean_pulses", 32'(pulses), 0);
    chk("clean_count", 32'(count_a), 0);
    chk("clean_locked_b", 32'(locked_b), 1);

    // Single flipped bit.
    send_stream(1'b1);
    chk("single_pulse", 32'(pulse_a), 1);
    chk("single_count", 32'(count_a), 1);
    chk("single_locked", 32'(locked_a), 1);
    pulses = 0;
    repeat (20) begin
      send_stream(1'b0);
      if (pulse_a) pulses++;
    end
    chk("single_after_pulses", 32'(pulses), 0);
    chk("single_after_count", 32'(count_a), 1);

    // Four consecutive errors drop lock on the fourth; relock 12 valid bits later.
    for (int i = 1; i <= 4; i++) begin
      send_stream(1'b1);
      chk("burst_pulse", 32'(pulse_a), 1);
      chk("burst_count", 32'(count_a), 32'(1 + i));
      chk("burst_locked", 32'(locked_a), (i < 4) ? 32'd1 : 32'd0);
    end
    first_lock = 0; pulses = 0;
    for (int k = 1; k <= 40 && first_lock == 0; k++) begin
      send_stream(1'b0);
      if (pulse_a) pulses++;
      if (locked_a) first_lock = k;
    end
    chk("relock_bit", 32'(first_lock), 12);
    chk("relock_pulses", 32'(pulses), 0);
    chk("relock_count", 32'(count_a), 5);

    // 20 isolated errors: 4-bit counter saturates, 16-bit keeps counting.
    repeat (20) begin
      send_stream(1'b1);
      send_stream(1'b0);
    end
    chk("sat_count_b", 32'(count_b), 15);
    chk("sat_count_a", 32'(count_a), 25);
    chk("sat_locked_a", 32'(locked_a), 1);
    chk("sat_locked_b", 32'(locked_b), 1);

    // Clear wins over a simultaneous increment, pulse still fires.
    err_clr = 1'b1;
    send_stream(1'b1);
    err_clr = 1'b0;
    chk("clr_pulse_a", 32'(pulse_a), 1);
    chk("clr_count_a", 32'(count_a), 0);
    chk("clr_pulse_b", 32'(pulse_b), 1);
    chk("clr_count_b", 32'(count_b), 0);
    send_stream(1'b0);
    chk("clr_next_pulse", 32'(pulse_a), 0);
    chk("clr_next_count", 32'(count_a), 0);

    // Async reset mid-lock, checked between clock edges.
    send_stream(1'b1);
    chk("prerst_count", 32'(count_a), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_locked", 32'(locked_a), 0);
    chk("async_count", 32'(count_a), 0);
    chk("async_pulse", 32'(pulse_a), 0);
    do_reset();

    // Random bit_valid gaps: lock still on the 12th valid bit.
    pos = 0; nv = 0; first_lock = 0; pulses = 0;
    for (int c = 0; c < 400 && first_lock == 0; c++) begin
      v = 1'($urandom_range(0, 1));
      if (v) begin
        send_stream(1'b0);
        nv++;
      end else begin
        send(1'($urandom_range(0, 1)), 1'b0);
      end
      if (pulse_a) pulses++;
      if (locked_a) first_lock = nv;
    end
    chk("gap_lock_bit", 32'(first_lock), 12);
    chk("gap_pulses", 32'(pulses), 0);
    send(1'b1, 1'b0);
    chk("gap_hold_locked", 32'(locked_a), 1);
    chk("gap_hold_pulse", 32'(pulse_a), 0);

    // Constant streams never lock and never count.
    do_reset();
    ever = 0;
    repeat (50) begin
      send(1'b0, 1'b1);
      if (locked_a) ever = 1;
    end
    chk("zeros_never_lock", 32'(ever), 0);
    chk("zeros_count", 32'(count_a), 0);
    do_reset();
    ever = 0;
    repeat (50) begin
      send(1'b1, 1'b1);
      if (locked_a || pulse_a) ever = 1;
    end
    chk("ones_never_lock", 32'(ever), 0);
    chk("ones_count", 32'(count_a), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
